// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor's dmem port.
//   A word-addressed RAM sits at the bottom of the address space. A four-word
//   MMIO window holds a TX FIFO (drained through a valid/ready stream), a
//   status register and a free-running cycle counter. Any other address is
//   unmapped.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   address_dmem/data/wren  processor request (word address, write data, write enable)
//   q_dmem                  registered read data, one cycle after the address
//   io_data/io_valid        TX FIFO head word and non-empty flag
//   io_ready                consumer takes io_data on this edge
module dmem_responder #(
  parameter int          ADDR_BITS  = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RAM_WORDS = 1 << ADDR_BITS;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLES = 2'd2;

  // ---------------- address decode ----------------
  logic        is_ram, is_mmio;
  logic [31:0] mmio_off;
  logic [1:0]  reg_sel;

  assign is_ram   = (address_dmem >> ADDR_BITS) == 32'd0;
  assign mmio_off = address_dmem - MMIO_BASE;
  // RAM wins if a parameter choice ever makes the two regions overlap
  assign is_mmio  = !is_ram && (mmio_off[31:2] == 30'd0);
  assign reg_sel  = mmio_off[1:0];

  logic wr_ram, wr_tx, wr_stat, wr_cyc, wr_unmapped;
  assign wr_ram      = wren && is_ram;
  assign wr_tx       = wren && is_mmio && (reg_sel == REG_TXDATA);
  assign wr_stat     = wren && is_mmio && (reg_sel == REG_STATUS);
  assign wr_cyc      = wren && is_mmio && (reg_sel == REG_CYCLES);
  assign wr_unmapped = wren && !is_ram && !is_mmio;

  // ---------------- RAM ----------------
  // Contents survive reset; only the write issued on a reset edge is dropped.
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (reset && wr_ram) mem[address_dmem[ADDR_BITS-1:0]] <= data;
  end

  // ---------------- TX FIFO ----------------
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  assign full     = count == DEPTH_C;
  assign io_valid = count != '0;
  // entries are never reset, so the head is masked while empty
  assign io_data  = io_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign pop      = io_valid && io_ready;
  // a pop on the same edge frees the slot a push into a full FIFO needs
  assign push_ok  = wr_tx && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset && push_ok) fifo_mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- sticky flags and cycle counter ----------------
  logic        tx_overflow, bus_err;
  logic [31:0] cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_overflow <= 1'b0;
      bus_err     <= 1'b0;
    end else if (wr_stat) begin
      tx_overflow <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      if (wr_tx && full && !pop) tx_overflow <= 1'b1;
      if (wr_unmapped)           bus_err     <= 1'b1;
    end
  end

  // a CYCLES write lands on 0, not 1, so software can time from a clean origin
  always_ff @(posedge clock) begin
    if (!reset)      cycles <= '0;
    else if (wr_cyc) cycles <= '0;
    else             cycles <= cycles + 32'd1;
  end

  // ---------------- read path ----------------
  logic [31:0] cnt32;
  logic [3:0]  cnt_sat;
  logic [31:0] status;
  logic [31:0] rd_data;

  always_comb begin
    cnt32   = 32'(count);
    cnt_sat = (cnt32 > 32'd15) ? 4'd15 : cnt32[3:0];
    status  = {24'd0, cnt_sat, bus_err, tx_overflow, !io_valid, full};
  end

  always_comb begin
    rd_data = 32'd0;
    if (is_ram) begin
      // write-first: a read of the word being written returns the new data
      rd_data = wren ? data : mem[address_dmem[ADDR_BITS-1:0]];
    end else if (is_mmio) begin
      case (reg_sel)
        REG_STATUS: rd_data = status;
        REG_CYCLES: rd_data = cycles;
        default:    rd_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) q_dmem <= 32'd0;
    else        q_dmem <= rd_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MB    = 32'hFFFF_FF00;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [31:0] io_data;
  logic        io_valid;
  logic        io_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.ADDR_BITS(12), .FIFO_DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .io_data(io_data), .io_valid(io_valid),
    .io_ready(io_ready)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [31:0] ram_m [int];
  logic [31:0] fifo_q [$];
  logic [31:0] cyc_m = '0;
  bit          ovf_m = 0;
  bit          berr_m = 0;
  logic [31:0] exp_q = '0;

  function automatic logic [31:0] status_m();
    int n = fifo_q.size();
    return 32'((n == DEPTH) ? 1 : 0) | 32'((n == 0) ? 2 : 0) | 32'(ovf_m ? 4 : 0)
         | 32'(berr_m ? 8 : 0) | 32'(((n > 15) ? 15 : n) << 4);
  endfunction

  function automatic logic [31:0] head_m();
    return (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
  endfunction

  // One clock edge of the bus as the rules describe it; read values use pre-edge state.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input bit w,
                            input bit r, input bit rst_n);
    longint ua = longint'(a);
    bit in_ram = ua < 4096;
    bit in_mm  = !in_ram && ua >= longint'(MB) && ua <= longint'(MB) + 3;
    longint off = ua - longint'(MB);
    bit was_full, popped;
    if (!rst_n) begin
      exp_q = 0; fifo_q.delete(); cyc_m = 0; ovf_m = 0; berr_m = 0;
      return;
    end
    if (in_ram)                 exp_q = w ? d : (ram_m.exists(int'(ua)) ? ram_m[int'(ua)] : 32'hx);
    else if (in_mm && off == 1) exp_q = status_m();
    else if (in_mm && off == 2) exp_q = cyc_m;
    else                        exp_q = 0;
    was_full = fifo_q.size() == DEPTH;
    popped = r && fifo_q.size() > 0;
    if (popped) void'(fifo_q.pop_front());
    if (w && in_mm && off == 0) begin
      if (was_full && !popped) ovf_m = 1;
      else fifo_q.push_back(d);
    end
    if (w && in_ram) ram_m[int'(ua)] = d;
    if (w && !in_ram && !in_mm) berr_m = 1;
    if (w && in_mm && off == 1) begin ovf_m = 0; berr_m = 0; end
    if (w && in_mm && off == 2) cyc_m = 0;
    else cyc_m = cyc_m + 1;
  endtask

  // Drive one bus cycle, advance the model, settle just after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w,
                      input bit r, input bit rst_n);
    address_dmem = a; data = d; wren = w; io_ready = r; reset = rst_n;
    model_edge(a, d, w, r, rst_n);
    @(posedge clock);
    #1;
    wren = 0; io_ready = 0; reset = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(32'd0, 32'd0, 0, 0, 0);
    step(32'd5, 32'h1, 1, 1, 0);
    total++; if (q_dmem !== 32'd0) begin bad++; $display("FAIL reset_q got=%h want=0", q_dmem); end
    total++; if (io_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", io_valid); end
    total++; if (io_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", io_data); end
  endtask

  task automatic test_ram();
    step(32'd5, 32'hDEAD_BEEF, 1, 0, 1);
    step(32'd5, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_read got=%h want=deadbeef", q_dmem); end
  endtask

  task automatic test_raw();
    step(32'd7, 32'hAAAA_0000, 1, 0, 1);
    step(32'd7, 32'h0000_1234, 1, 0, 1);
    total++; if (q_dmem !== 32'h1234) begin bad++; $display("FAIL raw_write_first got=%h want=1234", q_dmem); end
    step(32'd7, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'h1234) begin bad++; $display("FAIL raw_readback got=%h want=1234", q_dmem); end
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 9; i++) step(MB, 32'(i), 1, 0, 1);
    step(MB + 1, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'h85) begin bad++; $display("FAIL fill_status got=%h want=85", q_dmem); end
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (io_valid !== 1'b1 || io_data !== 32'(i)) begin
        bad++; $display("FAIL drain_order got=%b/%h want=1/%h", io_valid, io_data, 32'(i));
      end
      step(MB + 3, 32'd0, 0, 1, 1);
    end
    total++; if (io_valid !== 1'b0 || io_data !== 32'd0) begin bad++; $display("FAIL drain_empty got=%b/%h want=0/0", io_valid, io_data); end
    step(MB + 1, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'h06) begin bad++; $display("FAIL drain_status got=%h want=06", q_dmem); end
  endtask

  task automatic test_full_push_pop();
    step(MB + 1, 32'hFFFF_FFFF, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(MB, 32'h100 + 32'(i), 1, 0, 1);
    step(MB, 32'h200, 1, 1, 1);
    total++; if (io_data !== 32'h101) begin bad++; $display("FAIL fpp_head got=%h want=101", io_data); end
    step(MB + 1, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'h81) begin bad++; $display("FAIL fpp_status got=%h want=81", q_dmem); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (io_valid !== 1'b1 || io_data !== head_m()) begin
        bad++; $display("FAIL fpp_drain got=%b/%h want=1/%h", io_valid, io_data, head_m());
      end
      step(MB + 3, 32'd0, 0, 1, 1);
    end
    total++; if (io_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b want=0", io_valid); end
  endtask

  task automatic test_cycles();
    step(32'd0, 32'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(MB + 3, 32'd0, 0, 0, 1);
    step(MB + 2, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'd10) begin bad++; $display("FAIL cycles_10 got=%0d want=10", q_dmem); end
    step(MB + 2, 32'h5555_5555, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(MB + 2, 32'd0, 0, 0, 1);
      total++; if (q_dmem !== 32'(i)) begin bad++; $display("FAIL cycles_clear got=%0d want=%0d", q_dmem, i); end
    end
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    release dut.cycles;
    cyc_m = 32'hFFFF_FFFF;
    step(MB + 2, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycles_max got=%h want=ffffffff", q_dmem); end
    step(MB + 2, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'd0) begin bad++; $display("FAIL cycles_wrap got=%h want=0", q_dmem); end
  endtask

  task automatic test_unmapped_and_reset();
    step(32'd0, 32'hA5A5_A5A5, 1, 0, 1);
    step(32'h0001_0000, 32'h1111_1111, 1, 0, 1);
    total++; if (q_dmem !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h want=0", q_dmem); end
    step(MB + 1, 32'd0, 0, 0, 1);
    total++; if (q_dmem[3] !== 1'b1 || q_dmem !== exp_q) begin bad++; $display("FAIL bus_err_set got=%h want=%h", q_dmem, exp_q); end
    step(32'd0, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'hA5A5_A5A5) begin bad++; $display("FAIL unmapped_ram_intact got=%h want=a5a5a5a5", q_dmem); end
    step(MB + 1, 32'h0, 1, 0, 1);
    step(MB + 1, 32'd0, 0, 0, 1);
    total++; if (q_dmem[3:2] !== 2'b00 || q_dmem !== exp_q) begin bad++; $display("FAIL sticky_clear got=%h want=%h", q_dmem, exp_q); end
    for (int i = 0; i < 3; i++) step(MB, 32'hC0 + 32'(i), 1, 0, 1);
    total++; if (io_valid !== 1'b1) begin bad++; $display("FAIL queued got=%b want=1", io_valid); end
    step(32'd5, 32'd0, 1, 1, 0);
    total++; if (io_valid !== 1'b0 || io_data !== 32'd0 || q_dmem !== 32'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%h want=0/0/0", io_valid, io_data, q_dmem);
    end
    step(32'd5, 32'd0, 0, 0, 1);
    total++; if (q_dmem !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_keeps got=%h want=deadbeef", q_dmem); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 16; i++) step(32'(i), $urandom, 1, 0, 1);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 32'($urandom_range(0, 15));
      else if (sel < 9)  a = MB + 32'($urandom_range(0, 3));
      else               a = 32'h0000_1000 + 32'($urandom_range(0, 32'h00FF_0000));
      step(a, $urandom, $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) != 0);
      total++;
      if (q_dmem !== exp_q || io_valid !== (fifo_q.size() > 0) || io_data !== head_m()) begin
        bad++;
        $display("FAIL random a=%h got q=%h v=%b d=%h want q=%h v=%b d=%h", a, q_dmem, io_valid,
                 io_data, exp_q, fifo_q.size() > 0, head_m());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_raw();
    test_fifo_fill();
    test_full_push_pop();
    test_cycles();
    test_unmapped_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
